// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub: wide add/subtract through one 4-bit slice,
// one nibble per clock, carry rippled through a register.
module nibble_serial_addsub #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op_sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         overflow
);

  localparam int IW = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e        state_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          carry_q;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  result_q;
  logic          cout_q;
  logic          ovf_q;

  logic [3:0]    a_nib_d;
  logic [3:0]    b_nib_d;
  logic [3:0]    sum_d;
  logic          cout_d;
  logic          last_d;
  logic          ovf_d;

  // Select the operand nibbles at idx and run them through the slice.
  always_comb begin
    a_nib_d = 4'h0;
    b_nib_d = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IW'(i)) begin
        a_nib_d = a_q[4*i +: 4];
        b_nib_d = b_q[4*i +: 4];
      end
    end
    {cout_d, sum_d} = {1'b0, a_nib_d}
                    + {1'b0, b_nib_d}
                    + {4'h0, carry_q};
    last_d = (idx_q == IW'(NIBBLES - 1));
    ovf_d  = (a_q[W-1] == b_q[W-1])
          && (sum_d[3] != a_q[W-1]);
  end

  // Control FSM plus operand, carry and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= op_sub ? ~b : b;
            carry_q <= op_sub;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) begin
              result_q[4*i +: 4] <= sum_d;
            end
          end
          carry_q <= cout_d;
          idx_q   <= idx_q + IW'(1);
          if (last_d) begin
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Bench for nibble_serial_addsub: directed tables, corner sequences
// and random operands against an arithmetic reference model.
module tb_nibble_serial_addsub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 4-nibble instance
  logic        iv4, ir4, sub4, ov4, or4, c4, o4;
  logic [15:0] a4, b4, r4;
  // 1-nibble instance
  logic        iv1, ir1, sub1, ov1, or1, c1, o1;
  logic [3:0]  a1, b1, r1;

  nibble_serial_addsub #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(iv4), .in_ready(ir4),
    .op_sub(sub4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(or4),
    .result(r4), .carry_out(c4), .overflow(o4)
  );

  nibble_serial_addsub #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(iv1), .in_ready(ir1),
    .op_sub(sub1), .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(or1),
    .result(r1), .carry_out(c1), .overflow(o1)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] r;
    logic        c;
    logic        o;
  } vec_t;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on a w-bit word.
  task automatic model(input int w, input longint a, input longint b,
                       input bit sub, output longint r,
                       output bit c, output bit o);
    longint m, full, sa, sb, s;
    m = longint'(1) << w;
    if (sub) begin
      full = a - b;
      c = (a >= b);
    end else begin
      full = a + b;
      c = (full >= m);
    end
    r = ((full % m) + m) % m;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    s = sub ? sa - sb : sa + sb;
    o = (s < -(m / 2)) || (s >= m / 2);
  endtask

  task automatic op4(input logic [15:0] a, input logic [15:0] b,
                     input logic sub, output logic [15:0] r,
                     output logic c, output logic o,
                     output int lat);
    int n;
    @(negedge clk);
    iv4 = 1'b1; a4 = a; b4 = b; sub4 = sub; or4 = 1'b0;
    n = 0;
    while (!ir4 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    iv4 = 1'b0;
    a4 = 16'($urandom); b4 = 16'($urandom); sub4 = 1'($urandom);
    lat = 0;
    while (!ov4 && lat < 20) begin @(posedge clk); #1; lat++; end
    r = r4; c = c4; o = o4;
    @(negedge clk); or4 = 1'b1;
    @(posedge clk); #1; or4 = 1'b0;
    chk("in_ready after handshake", 64'(ir4), 64'd1);
  endtask

  task automatic op1(input logic [3:0] a, input logic [3:0] b,
                     input logic sub, output logic [3:0] r,
                     output logic c, output logic o,
                     output int lat);
    int n;
    @(negedge clk);
    iv1 = 1'b1; a1 = a; b1 = b; sub1 = sub; or1 = 1'b0;
    n = 0;
    while (!ir1 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    iv1 = 1'b0;
    a1 = 4'($urandom); b1 = 4'($urandom); sub1 = 1'($urandom);
    lat = 0;
    while (!ov1 && lat < 20) begin @(posedge clk); #1; lat++; end
    r = r1; c = c1; o = o1;
    @(negedge clk); or1 = 1'b1;
    @(posedge clk); #1; or1 = 1'b0;
  endtask

  initial begin
    vec_t        t4[6];
    vec_t        t1[3];
    logic [15:0] r;
    logic [3:0]  rn;
    logic        c, o;
    int          lat;
    longint      er;
    bit          ec, eo;
    bit          seen;

    t4[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    t4[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    t4[2] = '{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0};
    t4[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    t4[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    t4[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    t1[0] = '{16'hA, 16'h5, 1'b0, 16'hF, 1'b0, 1'b0};
    t1[1] = '{16'h7, 16'h3, 1'b1, 16'h4, 1'b1, 1'b0};
    t1[2] = '{16'h7, 16'h1, 1'b0, 16'h8, 1'b0, 1'b1};

    rst = 1'b1;
    iv4 = 0; sub4 = 0; a4 = 0; b4 = 0; or4 = 0;
    iv1 = 0; sub1 = 0; a1 = 0; b1 = 0; or1 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 64'(ir4), 64'd1);
    chk("reset out_valid", 64'(ov4), 64'd0);
    chk("reset result", 64'(r4), 64'd0);
    chk("reset flags", 64'({c4, o4}), 64'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      op4(t4[i].a, t4[i].b, t4[i].sub, r, c, o, lat);
      chk($sformatf("vec4[%0d] result", i), 64'(r), 64'(t4[i].r));
      chk($sformatf("vec4[%0d] carry", i), 64'(c), 64'(t4[i].c));
      chk($sformatf("vec4[%0d] ovf", i), 64'(o), 64'(t4[i].o));
      chk($sformatf("vec4[%0d] latency", i), 64'(lat), 64'd4);
    end

    for (int i = 0; i < 3; i++) begin
      op1(t1[i].a[3:0], t1[i].b[3:0], t1[i].sub, rn, c, o, lat);
      chk($sformatf("vec1[%0d] result", i), 64'(rn), 64'(t1[i].r));
      chk($sformatf("vec1[%0d] carry", i), 64'(c), 64'(t1[i].c));
      chk($sformatf("vec1[%0d] ovf", i), 64'(o), 64'(t1[i].o));
      chk($sformatf("vec1[%0d] latency", i), 64'(lat), 64'd1);
    end

    // Backpressure: result held, new requests ignored.
    @(negedge clk);
    iv4 = 1'b1; a4 = 16'h1234; b4 = 16'h4321; sub4 = 1'b0;
    @(posedge clk); #1;
    a4 = 16'hFFFF; b4 = 16'hFFFF; sub4 = 1'b1;
    lat = 0;
    while (!ov4 && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("bp latency", 64'(lat), 64'd4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp result", 64'(r4), 64'h5555);
      chk("bp flags", 64'({c4, o4}), 64'd0);
      chk("bp out_valid", 64'(ov4), 64'd1);
      chk("bp in_ready", 64'(ir4), 64'd0);
    end
    @(negedge clk); or4 = 1'b1;
    @(posedge clk); #1;
    or4 = 1'b0; iv4 = 1'b0;
    chk("bp out_valid dropped", 64'(ov4), 64'd0);
    chk("bp in_ready back", 64'(ir4), 64'd1);

    // Reset in the middle of RUN.
    @(negedge clk);
    iv4 = 1'b1; a4 = 16'h1111; b4 = 16'h2222; sub4 = 1'b0;
    @(posedge clk); #1;
    iv4 = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst mid out_valid", 64'(ov4), 64'd0);
    chk("rst mid in_ready", 64'(ir4), 64'd1);
    chk("rst mid result", 64'(r4), 64'd0);
    chk("rst mid flags", 64'({c4, o4}), 64'd0);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ov4) seen = 1'b1;
    end
    chk("rst no stale out_valid", 64'(seen), 64'd0);
    op4(16'h0001, 16'h0001, 1'b0, r, c, o, lat);
    chk("post rst result", 64'(r), 64'h0002);
    chk("post rst latency", 64'(lat), 64'd4);

    // Random operands against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      logic        rs;
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      op4(ra, rb, rs, r, c, o, lat);
      model(16, longint'(ra), longint'(rb), rs, er, ec, eo);
      chk("rand4 result", 64'(r), 64'(er));
      chk("rand4 flags", 64'({c, o}), 64'({ec, eo}));
      chk("rand4 latency", 64'(lat), 64'd4);
    end
    for (int i = 0; i < 30; i++) begin
      logic [3:0] ra, rb;
      logic       rs;
      ra = 4'($urandom); rb = 4'($urandom); rs = 1'($urandom);
      op1(ra, rb, rs, rn, c, o, lat);
      model(4, longint'(ra), longint'(rb), rs, er, ec, eo);
      chk("rand1 result", 64'(rn), 64'(er));
      chk("rand1 flags", 64'({c, o}), 64'({ec, eo}));
      chk("rand1 latency", 64'(lat), 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
